packet_disassembler: RTL and testbench

//   Splits one wide response word into a sequence of narrow chunks for the SPI arbitrator.

---
 rtl/packet_disassembler.sv | 82 ++++++++
 tb/tb_packet_disassembler.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/packet_disassembler.sv
// packet_disassembler
//   Splits one wide message into num_chunks narrow chunks, MSB chunk first.
//   The chunks go out back to back with no bubble, so a downstream arbitrator
//   keeps its grant for the whole message. One idle cycle follows every message.
//
// Ports
//   clk       in   1          clock, all state updates on posedge
//   reset     in   1          asynchronous, active-low reset
//   req_val   in   1          upstream message valid
//   req_rdy   out  1          ready to accept a message (only in IDLE)
//   req_msg   in   nbits_in   message, latched on req_val & req_rdy
//   resp_val  out  1          chunk valid (only in SEND)
//   resp_rdy  in   1          downstream accepts the current chunk
//   resp_msg  out  nbits_out  current chunk
module packet_disassembler #(
  parameter int nbits_in  = 64,
  parameter int nbits_out = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_val,
  output logic                 req_rdy,
  input  logic [nbits_in-1:0]  req_msg,
  output logic                 resp_val,
  input  logic                 resp_rdy,
  output logic [nbits_out-1:0] resp_msg
);

  localparam int num_chunks = (nbits_in + nbits_out - 1) / nbits_out;
  localparam int cnt_nbits  = (num_chunks > 1) ? $clog2(num_chunks) : 1;
  localparam int PW         = num_chunks * nbits_out;
  localparam logic [cnt_nbits-1:0] LAST = cnt_nbits'(num_chunks - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                               state, state_d;
  logic [cnt_nbits-1:0]                 cnt, cnt_d;
  // Zero-extended message; element [num_chunks-1] is the MSB chunk (chunk 0).
  logic [num_chunks-1:0][nbits_out-1:0] msg_q, msg_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      msg_q <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      msg_q <= msg_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    msg_d   = msg_q;
    case (state)
      IDLE: begin
        if (req_val && req_rdy) begin
          msg_d   = PW'(req_msg);
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (resp_rdy) begin
          // Counter stays on the last chunk so resp_msg holds it while idle.
          if (cnt == LAST) state_d = IDLE;
          else             cnt_d   = cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Gating with reset keeps req_rdy low while reset is held; otherwise the
  // outputs depend on registered state only.
  assign req_rdy  = reset && (state == IDLE);
  assign resp_val = (state == SEND);
  assign resp_msg = msg_q[LAST - cnt];

endmodule

// File: tb/tb_packet_disassembler.sv
module tb_packet_disassembler;

  logic        clk = 1'b0;
  logic        reset;

  // 64-bit in, 16-bit chunks
  logic        req_val, req_rdy, resp_val, resp_rdy;
  logic [63:0] req_msg;
  logic [15:0] resp_msg;

  // 40-bit in, 16-bit chunks (non-multiple width)
  logic        b_req_val, b_req_rdy, b_resp_val, b_resp_rdy;
  logic [39:0] b_req_msg;
  logic [15:0] b_resp_msg;

  logic [15:0] exp_q[$];
  logic [15:0] e;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  packet_disassembler #(.nbits_in(64), .nbits_out(16)) dut (
    .clk(clk), .reset(reset),
    .req_val(req_val), .req_rdy(req_rdy), .req_msg(req_msg),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_msg(resp_msg)
  );

  packet_disassembler #(.nbits_in(40), .nbits_out(16)) dut40 (
    .clk(clk), .reset(reset),
    .req_val(b_req_val), .req_rdy(b_req_rdy), .req_msg(b_req_msg),
    .resp_val(b_resp_val), .resp_rdy(b_resp_rdy), .resp_msg(b_resp_msg)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: MSB-first chunk split of a 64-bit message.
  task automatic push64(input logic [63:0] m);
    for (int k = 0; k < 4; k++) exp_q.push_back(m[(3-k)*16 +: 16]);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req_val = 1'b0; req_msg = '0; resp_rdy = 1'b1;
    b_req_val = 1'b0; b_req_msg = '0; b_resp_rdy = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++; if (req_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_req_rdy got=%b exp=0", req_rdy); end
    n_tests++; if (resp_val !== 1'b0) begin n_fail++; $display("FAIL reset_resp_val got=%b exp=0", resp_val); end
    n_tests++; if (resp_msg !== 16'h0) begin n_fail++; $display("FAIL reset_resp_msg got=%h exp=0000", resp_msg); end
    tick();
    reset = 1'b1;
    @(negedge clk);
    n_tests++; if (req_rdy !== 1'b1) begin n_fail++; $display("FAIL post_reset_req_rdy got=%b exp=1", req_rdy); end
    n_tests++; if (resp_val !== 1'b0) begin n_fail++; $display("FAIL post_reset_resp_val got=%b exp=0", resp_val); end
    n_tests++; if (resp_msg !== 16'h0) begin n_fail++; $display("FAIL post_reset_resp_msg got=%h exp=0000", resp_msg); end
    tick();
  endtask

  task automatic test_single();
    req_val = 1'b1; req_msg = 64'h0123_4567_89AB_CDEF; resp_rdy = 1'b1;
    push64(req_msg);
    @(negedge clk);
    n_tests++; if (req_rdy !== 1'b1) begin n_fail++; $display("FAIL single_accept_rdy got=%b exp=1", req_rdy); end
    tick();
    req_val = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_tests++; if (resp_val !== 1'b1) begin n_fail++; $display("FAIL single_val[%0d] got=%b exp=1", k, resp_val); end
      n_tests++; if (req_rdy !== 1'b0) begin n_fail++; $display("FAIL single_rdy_busy[%0d] got=%b exp=0", k, req_rdy); end
      n_tests++; if (resp_msg !== e) begin n_fail++; $display("FAIL single_chunk[%0d] got=%h exp=%h", k, resp_msg, e); end
      tick();
    end
    @(negedge clk);
    n_tests++; if (resp_val !== 1'b0) begin n_fail++; $display("FAIL single_done_val got=%b exp=0", resp_val); end
    n_tests++; if (req_rdy !== 1'b1) begin n_fail++; $display("FAIL single_done_rdy got=%b exp=1", req_rdy); end
    n_tests++; if (resp_msg !== 16'hCDEF) begin n_fail++; $display("FAIL single_hold_last got=%h exp=cdef", resp_msg); end
    tick();
  endtask

  task automatic test_backpressure();
    req_val = 1'b1; req_msg = 64'h0123_4567_89AB_CDEF; resp_rdy = 1'b1;
    push64(req_msg);
    tick();
    req_val = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    n_tests++; if (resp_msg !== e) begin n_fail++; $display("FAIL bp_chunk0 got=%h exp=%h", resp_msg, e); end
    tick();
    // Stall on chunk 1; scribbling on req_msg must not matter.
    resp_rdy = 1'b0;
    req_msg  = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      n_tests++; if (resp_val !== 1'b1) begin n_fail++; $display("FAIL bp_stall_val[%0d] got=%b exp=1", s, resp_val); end
      n_tests++; if (resp_msg !== exp_q[0]) begin n_fail++; $display("FAIL bp_stall_msg[%0d] got=%h exp=%h", s, resp_msg, exp_q[0]); end
      tick();
    end
    resp_rdy = 1'b1;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_tests++; if (resp_val !== 1'b1) begin n_fail++; $display("FAIL bp_val[%0d] got=%b exp=1", k, resp_val); end
      n_tests++; if (resp_msg !== e) begin n_fail++; $display("FAIL bp_chunk[%0d] got=%h exp=%h", k, resp_msg, e); end
      tick();
    end
    @(negedge clk);
    n_tests++; if (resp_val !== 1'b0) begin n_fail++; $display("FAIL bp_done_val got=%b exp=0", resp_val); end
    tick();
  endtask

  task automatic test_back_to_back();
    req_val = 1'b1; req_msg = 64'h0123_4567_89AB_CDEF; resp_rdy = 1'b1;
    push64(req_msg);
    tick();
    req_msg = 64'h1111_2222_3333_4444;   // waits on req_val during SEND
    push64(req_msg);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_tests++; if (resp_val !== 1'b1) begin n_fail++; $display("FAIL b2b_a_val[%0d] got=%b exp=1", k, resp_val); end
      n_tests++; if (resp_msg !== e) begin n_fail++; $display("FAIL b2b_a_chunk[%0d] got=%h exp=%h", k, resp_msg, e); end
      tick();
    end
    @(negedge clk);
    n_tests++; if (resp_val !== 1'b0) begin n_fail++; $display("FAIL b2b_gap_val got=%b exp=0", resp_val); end
    n_tests++; if (req_rdy !== 1'b1) begin n_fail++; $display("FAIL b2b_gap_rdy got=%b exp=1", req_rdy); end
    tick();
    req_val = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_tests++; if (resp_val !== 1'b1) begin n_fail++; $display("FAIL b2b_b_val[%0d] got=%b exp=1", k, resp_val); end
      n_tests++; if (resp_msg !== e) begin n_fail++; $display("FAIL b2b_b_chunk[%0d] got=%h exp=%h", k, resp_msg, e); end
      tick();
    end
    @(negedge clk);
    n_tests++; if (resp_val !== 1'b0) begin n_fail++; $display("FAIL b2b_done_val got=%b exp=0", resp_val); end
    tick();
  endtask

  task automatic test_reset_mid();
    req_val = 1'b1; req_msg = 64'hDEAD_BEEF_CAFE_F00D; resp_rdy = 1'b1;
    push64(req_msg);
    tick();
    req_val = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_tests++; if (resp_msg !== e) begin n_fail++; $display("FAIL mid_chunk[%0d] got=%h exp=%h", k, resp_msg, e); end
      tick();
    end
    reset = 1'b0;
    #1;
    n_tests++; if (resp_val !== 1'b0) begin n_fail++; $display("FAIL mid_reset_val got=%b exp=0", resp_val); end
    n_tests++; if (req_rdy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_rdy got=%b exp=0", req_rdy); end
    n_tests++; if (resp_msg !== 16'h0) begin n_fail++; $display("FAIL mid_reset_msg got=%h exp=0000", resp_msg); end
    exp_q.delete();
    tick();
    reset = 1'b1;
    req_val = 1'b1; req_msg = 64'hA5A5_5A5A_0F0F_F0F0;
    push64(req_msg);
    tick();
    req_val = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_tests++; if (resp_val !== 1'b1) begin n_fail++; $display("FAIL mid_new_val[%0d] got=%b exp=1", k, resp_val); end
      n_tests++; if (resp_msg !== e) begin n_fail++; $display("FAIL mid_new_chunk[%0d] got=%h exp=%h", k, resp_msg, e); end
      tick();
    end
    @(negedge clk);
    n_tests++; if (resp_val !== 1'b0) begin n_fail++; $display("FAIL mid_new_done got=%b exp=0", resp_val); end
    tick();
  endtask

  task automatic test_non_multiple();
    logic [47:0] p;
    b_req_val = 1'b1; b_req_msg = 40'hAB_CDEF_1234; b_resp_rdy = 1'b1;
    p = {8'h00, b_req_msg};
    for (int k = 0; k < 3; k++) exp_q.push_back(p[(2-k)*16 +: 16]);
    tick();
    b_req_val = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_tests++; if (b_resp_val !== 1'b1) begin n_fail++; $display("FAIL nm_val[%0d] got=%b exp=1", k, b_resp_val); end
      n_tests++; if (b_resp_msg !== e) begin n_fail++; $display("FAIL nm_chunk[%0d] got=%h exp=%h", k, b_resp_msg, e); end
      tick();
    end
    @(negedge clk);
    n_tests++; if (b_resp_val !== 1'b0) begin n_fail++; $display("FAIL nm_done_val got=%b exp=0", b_resp_val); end
    n_tests++; if (b_req_rdy !== 1'b1) begin n_fail++; $display("FAIL nm_done_rdy got=%b exp=1", b_req_rdy); end
    tick();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_non_multiple();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
